// File: rtl/uart_pkg.sv
// uart_pkg: frame constants and FSM state type shared by the UART transmitter and receiver.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL = 1'b1;
  localparam logic UART_IDLE_LVL = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read; rdata is valid whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic we, re;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign we = wr && !full;
  assign re = rd && !empty;
  assign rdata = mem_q[rp_q];
  always_ff @(posedge clk)
    if (we) mem_q[wp_q] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(we);
      rp_q <= rp_q + AW'(re);
      cnt_q <= cnt_q + (AW+1)'(we) - (AW+1)'(re);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 LSB-first UART transmitter fed by a small byte FIFO.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int KBAUD = 10416,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_serial,
  output logic       tx_done,
  output logic       busy
);
  localparam int BW = $clog2(KBAUD);
  localparam logic [BW-1:0] BAUD_LAST = BW'(KBAUD - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  uart_state_e state_q;
  logic [BW-1:0] baud_q;
  logic [2:0] bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [7:0] fifo_data;
  logic tx_q, done_q, empty, pop;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr(tx_wr),
    .wdata(tx_data),
    .rd(pop),
    .rdata(fifo_data),
    .full(tx_full),
    .empty(empty)
  );
  // A pop at the end of the stop bit chains the next frame with no idle gap.
  assign pop = !empty && (state_q == IDLE || (state_q == STOP && baud_q == '0));
  assign busy = state_q != IDLE || !empty;
  assign tx_serial = tx_q;
  assign tx_done = done_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= UART_IDLE_LVL;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      baud_q <= baud_q != '0 ? baud_q - 1'b1 : baud_q;
      tx_q <= state_q == START ? UART_START_LVL :
              state_q == DATA  ? shift_q[0] :
              state_q == STOP  ? UART_STOP_LVL : UART_IDLE_LVL;
      case (state_q)
        IDLE: if (pop) begin
          shift_q <= fifo_data;
          baud_q <= BAUD_LAST;
          state_q <= START;
        end
        START: if (baud_q == '0) begin
          baud_q <= BAUD_LAST;
          bit_q <= '0;
          state_q <= DATA;
        end
        DATA: if (baud_q == '0) begin
          shift_q <= shift_q >> 1;
          baud_q <= BAUD_LAST;
          bit_q <= bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_q <= STOP;
        end
        default: if (baud_q == '0) begin
          done_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_data;
            baud_q <= BAUD_LAST;
            state_q <= START;
          end else state_q <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, latency, back-to-back frames, FIFO overflow and reset.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] tx_data;
  logic tx_wr;
  logic tx_full, tx_serial, tx_done, busy;
  int n_pass = 0;
  int n_total = 0;
  uart_tx_fifo #(.KBAUD(16), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_wr(tx_wr),
    .tx_full(tx_full),
    .tx_serial(tx_serial),
    .tx_done(tx_done),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  // Walks one frame from cycle s of its start bit; each bit must hold its level for
  // all its clocks, tx_done must pulse only on the last stop-bit clock.
  task automatic frame(input logic [7:0] b, input int s, input logic busy_end, input string tag);
    logic lvl, ok, last;
    for (int i = 0; i < 10; i++) begin
      lvl = i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
      ok = 1'b1;
      for (int j = 0; j < (i == 0 ? 16 - s : 16); j++) begin
        last = i == 9 && j == 15;
        ok &= tx_serial === lvl && tx_done === last && busy === (last ? busy_end : 1'b1);
        tick();
      end
      chk($sformatf("%s bit%0d line=%0b", tag, i, lvl), 32'(ok), 32'd1);
    end
  endtask
  initial begin
    logic ok;
    rst = 1'b1;
    tx_wr = 1'b0;
    tx_data = 8'h00;
    #1;
    chk("por tx_serial", 32'(tx_serial), 32'd1);
    chk("por busy", 32'(busy), 32'd0);
    chk("por tx_full", 32'(tx_full), 32'd0);
    chk("por tx_done", 32'(tx_done), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    tx_data = 8'hA5;
    tx_wr = 1'b1;
    tick();
    tx_wr = 1'b0;
    chk("a5 busy after write", 32'(busy), 32'd1);
    chk("a5 line E", 32'(tx_serial), 32'd1);
    tick();
    chk("a5 line E+1", 32'(tx_serial), 32'd1);
    tick();
    frame(8'hA5, 0, 1'b0, "a5");
    ok = 1'b1;
    repeat (20) begin
      ok &= tx_serial === 1'b1 && tx_done === 1'b0 && busy === 1'b0;
      tick();
    end
    chk("a5 idle after", 32'(ok), 32'd1);
    tx_wr = 1'b1;
    tx_data = 8'h00;
    tick();
    tx_data = 8'hFF;
    tick();
    tx_wr = 1'b0;
    tick();
    frame(8'h00, 0, 1'b1, "b2b 00");
    frame(8'hFF, 0, 1'b0, "b2b ff");
    repeat (5) tick();
    for (int k = 1; k <= 6; k++) begin
      tx_data = 8'(k);
      tx_wr = 1'b1;
      tick();
      if (k >= 3) chk($sformatf("ovf start cyc%0d", k - 3), 32'(tx_serial), 32'd0);
      if (k >= 5) chk($sformatf("ovf full k%0d", k), 32'(tx_full), 32'd1);
    end
    tx_wr = 1'b0;
    frame(8'h01, 3, 1'b1, "ovf 01");
    frame(8'h02, 0, 1'b1, "ovf 02");
    frame(8'h03, 0, 1'b1, "ovf 03");
    frame(8'h04, 0, 1'b1, "ovf 04");
    frame(8'h05, 0, 1'b0, "ovf 05");
    ok = 1'b1;
    repeat (40) begin
      ok &= tx_serial === 1'b1 && busy === 1'b0;
      tick();
    end
    chk("ovf 06 dropped", 32'(ok), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tx_data = 8'(k * 8'h11);
      tx_wr = 1'b1;
      tick();
    end
    chk("fp full", 32'(tx_full), 32'd1);
    tx_data = 8'hAA;
    fork
      frame(8'h11, 2, 1'b1, "fp 11");
      begin
        for (int i = 0; i < 200; i++) begin
          if (tx_done) break;
          tick();
        end
        tx_data = 8'hBB;
        tick();
        tx_wr = 1'b0;
      end
    join
    chk("fp still full", 32'(tx_full), 32'd1);
    frame(8'h22, 0, 1'b1, "fp 22");
    frame(8'h33, 0, 1'b1, "fp 33");
    frame(8'h44, 0, 1'b1, "fp 44");
    frame(8'h55, 0, 1'b1, "fp 55");
    frame(8'hBB, 0, 1'b0, "fp bb");
    repeat (3) tick();
    tx_data = 8'h00;
    tx_wr = 1'b1;
    repeat (5) tick();
    tx_wr = 1'b0;
    chk("rst pre full", 32'(tx_full), 32'd1);
    repeat (40) tick();
    chk("rst pre line", 32'(tx_serial), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst tx_serial", 32'(tx_serial), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst tx_full", 32'(tx_full), 32'd0);
    chk("rst tx_done", 32'(tx_done), 32'd0);
    tick();
    rst = 1'b0;
    ok = 1'b1;
    repeat (200) begin
      ok &= tx_serial === 1'b1 && busy === 1'b0 && tx_done === 1'b0;
      tick();
    end
    chk("rst queue lost", 32'(ok), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
